// File: rtl/caliptra_axil2apb_bridge.sv
// rtl/caliptra_axil2apb_bridge.sv - AXI4-Lite slave to multi-target APB requester
module caliptra_axil2apb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 2,
  parameter int SEL_LSB        = 16,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8,
  localparam int SEL_W         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                             core_clk,
  input  logic                             S_AXI_ARESETN,
  input  logic                             S_AXI_AWVALID,
  output logic                             S_AXI_AWREADY,
  input  logic [ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                       S_AXI_AWPROT,
  input  logic                             S_AXI_WVALID,
  output logic                             S_AXI_WREADY,
  input  logic [DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [STRB_WIDTH-1:0]            S_AXI_WSTRB,
  output logic                             S_AXI_BVALID,
  input  logic                             S_AXI_BREADY,
  output logic [1:0]                       S_AXI_BRESP,
  input  logic                             S_AXI_ARVALID,
  output logic                             S_AXI_ARREADY,
  input  logic [ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                       S_AXI_ARPROT,
  output logic                             S_AXI_RVALID,
  input  logic                             S_AXI_RREADY,
  output logic [DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                       S_AXI_RRESP,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STRB_WIDTH-1:0]            PSTRB,
  output logic [2:0]                       PPROT,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [2:0]            prot_q, prot_d;
  logic                  write_q, write_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic                  last_was_write_q, last_was_write_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [31:0]           cnt_q, cnt_d;

  logic                  wr_cand, rd_cand, grant_wr, grant_rd;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [SEL_W-1:0]      req_idx;
  logic                  req_decerr;
  logic                  sel_ready, sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  // Pick the PREADY/PSLVERR/PRDATA of the addressed target; other slices are ignored
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(idx_q) == i) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Request arbitration and decode: a write needs AW and W together; ties alternate
  always_comb begin
    wr_cand    = S_AXI_AWVALID & S_AXI_WVALID;
    rd_cand    = S_AXI_ARVALID;
    grant_wr   = (state_q == IDLE) & S_AXI_ARESETN & wr_cand & (~rd_cand | ~last_was_write_q);
    grant_rd   = (state_q == IDLE) & S_AXI_ARESETN & rd_cand & ~grant_wr;
    req_addr   = grant_wr ? S_AXI_AWADDR : S_AXI_ARADDR;
    req_idx    = req_addr[SEL_LSB +: SEL_W];
    req_decerr = 32'(req_idx) >= NUM_SLAVES;
  end

  // Next-state and datapath: IDLE -> SETUP -> ACCESS -> RESP, decode errors skip the APB
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    strb_d           = strb_q;
    prot_d           = prot_q;
    write_d          = write_q;
    idx_d            = idx_q;
    last_was_write_d = last_was_write_q;
    resp_d           = resp_q;
    rdata_d          = rdata_q;
    cnt_d            = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_wr || grant_rd) begin
          addr_d           = req_addr;
          idx_d            = req_idx;
          write_d          = grant_wr;
          last_was_write_d = grant_wr;
          cnt_d            = '0;
          if (grant_wr) begin
            wdata_d = S_AXI_WDATA;
            strb_d  = S_AXI_WSTRB;
            prot_d  = S_AXI_AWPROT;
          end else begin
            strb_d  = '0;
            prot_d  = S_AXI_ARPROT;
          end
          if (req_decerr) begin
            resp_d  = 2'b11;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          resp_d  = sel_err ? 2'b10 : 2'b00;
          rdata_d = write_q ? '0 : sel_rdata;
          state_d = RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          resp_d  = 2'b10;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP: begin
        if ((write_q && S_AXI_BREADY) || (!write_q && S_AXI_RREADY)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers
  always_ff @(posedge core_clk) begin
    if (!S_AXI_ARESETN) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      wdata_q          <= '0;
      strb_q           <= '0;
      prot_q           <= '0;
      write_q          <= 1'b0;
      idx_q            <= '0;
      last_was_write_q <= 1'b0;
      resp_q           <= '0;
      rdata_q          <= '0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      strb_q           <= strb_d;
      prot_q           <= prot_d;
      write_q          <= write_d;
      idx_q            <= idx_d;
      last_was_write_q <= last_was_write_d;
      resp_q           <= resp_d;
      rdata_q          <= rdata_d;
      cnt_q            <= cnt_d;
    end
  end

  // Bus outputs derived from the registered transaction
  always_comb begin
    S_AXI_AWREADY = grant_wr;
    S_AXI_WREADY  = grant_wr;
    S_AXI_ARREADY = grant_rd;
    S_AXI_BVALID  = (state_q == RESP) & write_q;
    S_AXI_RVALID  = (state_q == RESP) & ~write_q;
    S_AXI_BRESP   = S_AXI_BVALID ? resp_q : 2'b00;
    S_AXI_RRESP   = S_AXI_RVALID ? resp_q : 2'b00;
    S_AXI_RDATA   = S_AXI_RVALID ? rdata_q : '0;
    PENABLE       = (state_q == ACCESS);
    PADDR         = addr_q;
    PWRITE        = write_q;
    PWDATA        = wdata_q;
    PSTRB         = strb_q;
    PPROT         = prot_q;
    PSEL          = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      PSEL[i] = ((state_q == SETUP) || (state_q == ACCESS)) && (int'(idx_q) == i);
    end
  end

endmodule

// File: tb/tb_caliptra_axil2apb_bridge.sv
// tb/tb_caliptra_axil2apb_bridge.sv - directed self-checking bench for the AXI-Lite to APB bridge
module tb_caliptra_axil2apb_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [NS-1:0] psel;
  logic          penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0] pready, pslverr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  caliptra_axil2apb_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SEL_LSB(16), .TIMEOUT_CYCLES(4)
  ) dut (
    .core_clk(clk), .S_AXI_ARESETN(resetn),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .PSEL(psel), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
    .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  task automatic start_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d; wstrb = 4'hF; awprot = 3'b000;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic wait_bvalid(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      #1;
      if (bvalid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0)
      $display("FAIL reset_handshakes got %b exp 00000", {awready, wready, arready, bvalid, rvalid});
    else pass_cnt++;
    total_cnt++;
    if ({psel, penable, bresp, rresp} !== 8'b0)
      $display("FAIL reset_apb_resp got %b exp 0", {psel, penable, bresp, rresp});
    else pass_cnt++;
    total_cnt++;
    if ({rdata, paddr, pwdata, pstrb, pprot} !== '0)
      $display("FAIL reset_data got nonzero %h %h %h", rdata, paddr, pwdata);
    else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_write;
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h0000_0010; wdata = 32'hA5A5_5A5A;
    wstrb = 4'hF; awprot = 3'b010;
    #1;
    total_cnt++;
    if ({awready, wready} !== 2'b11) $display("FAIL wr_accept got %b exp 11", {awready, wready});
    else pass_cnt++;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    total_cnt++;
    if ({psel, penable, pwrite} !== {3'b001, 1'b0, 1'b1})
      $display("FAIL wr_setup got psel=%b en=%b wr=%b exp 001/0/1", psel, penable, pwrite);
    else pass_cnt++;
    total_cnt++;
    if ({paddr, pwdata, pstrb, pprot} !== {32'h10, 32'hA5A5_5A5A, 4'hF, 3'b010})
      $display("FAIL wr_setup_bus got %h %h %h %b", paddr, pwdata, pstrb, pprot);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({psel, penable} !== 4'b0011) $display("FAIL wr_access got %b exp 0011", {psel, penable});
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({bvalid, bresp, psel, penable} !== {1'b1, 2'b00, 3'b000, 1'b0})
      $display("FAIL wr_resp got bvalid=%b bresp=%b psel=%b en=%b", bvalid, bresp, psel, penable);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (bvalid !== 1'b0) $display("FAIL wr_done got %b exp 0", bvalid);
    else pass_cnt++;
  endtask

  task automatic test_read_wait;
    pready = 3'b001; pslverr = 3'b001;
    prdata = {32'h0BAD_0BAD, 32'hDEAD_BEEF, 32'h1234_5678};
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h0001_0004; arprot = 3'b001;
    #1;
    total_cnt++;
    if (arready !== 1'b1) $display("FAIL rd_accept got %b exp 1", arready);
    else pass_cnt++;
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    total_cnt++;
    if ({psel, penable, pwrite, pstrb, paddr} !== {3'b010, 1'b0, 1'b0, 4'h0, 32'h0001_0004})
      $display("FAIL rd_setup got psel=%b en=%b wr=%b strb=%h addr=%h", psel, penable, pwrite, pstrb, paddr);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if ({psel, penable} !== 4'b0101) $display("FAIL rd_wait3 got %b exp 0101", {psel, penable});
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({psel, penable, rvalid} !== 5'b01010) $display("FAIL rd_wait4 got %b exp 01010", {psel, penable, rvalid});
    else pass_cnt++;
    pready = 3'b011;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'hDEAD_BEEF})
      $display("FAIL rd_resp got rvalid=%b rresp=%b rdata=%h exp 1/00/deadbeef", rvalid, rresp, rdata);
    else pass_cnt++;
    pready = 3'b111; pslverr = 3'b000;
    @(negedge clk);
    #1;
    total_cnt++;
    if (rvalid !== 1'b0) $display("FAIL rd_done got %b exp 0", rvalid);
    else pass_cnt++;
  endtask

  task automatic test_decerr;
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h0003_0000;
    #1;
    total_cnt++;
    if (arready !== 1'b1) $display("FAIL dec_accept got %b exp 1", arready);
    else pass_cnt++;
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    total_cnt++;
    if ({psel, penable, rvalid, rresp, rdata} !== {3'b000, 1'b0, 1'b1, 2'b11, 32'h0})
      $display("FAIL dec_resp got psel=%b rvalid=%b rresp=%b rdata=%h exp 000/1/11/0", psel, rvalid, rresp, rdata);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({rvalid, psel} !== 4'b0) $display("FAIL dec_done got %b exp 0000", {rvalid, psel});
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    int n;
    bit ok;
    pready = 3'b000;
    start_write(32'h0000_0020, 32'h1111_2222);
    n = 0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bvalid) begin
        ok = 1'b1;
        break;
      end
      if (penable) n++;
      @(negedge clk);
    end
    total_cnt++;
    if (!ok || n != 4) $display("FAIL to_penable_cycles got %0d (resp seen %0d) exp 4", n, ok);
    else pass_cnt++;
    total_cnt++;
    if ({bresp, psel, penable} !== {2'b10, 3'b000, 1'b0})
      $display("FAIL to_bresp got bresp=%b psel=%b en=%b exp 10/000/0", bresp, psel, penable);
    else pass_cnt++;
    pready = 3'b111; pslverr = 3'b001;
    @(negedge clk);
    start_write(32'h0000_0030, 32'h3333_4444);
    wait_bvalid(10, ok);
    total_cnt++;
    if (!ok || bresp !== 2'b10) $display("FAIL slverr_bresp got %b (seen %0d) exp 10", bresp, ok);
    else pass_cnt++;
    pslverr = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_arbitration;
    bit ok;
    int grants;
    logic [3:0] order;
    bit both;
    start_write(32'h0000_0040, 32'h5555_6666);
    wait_bvalid(10, ok);
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    awaddr = 32'h0000_0044; wdata = 32'h7777_8888; wstrb = 4'h3; araddr = 32'h0000_0048;
    grants = 0; order = '0; both = 1'b0;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      #1;
      if (awready && arready) both = 1'b1;
      if (awready || arready) begin
        order[3-grants] = awready;
        grants++;
      end
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    total_cnt++;
    if (grants != 4 || order !== 4'b0101)
      $display("FAIL arb_order got %b (%0d grants) exp 0101 (R,W,R,W)", order, grants);
    else pass_cnt++;
    total_cnt++;
    if (both) $display("FAIL arb_exclusive got both readys high exp one");
    else pass_cnt++;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit ok;
    int bad;
    bready = 1'b0;
    start_write(32'h0000_0050, 32'h9999_AAAA);
    wait_bvalid(10, ok);
    total_cnt++;
    if (!ok) $display("FAIL bp_bvalid got 0 exp 1");
    else pass_cnt++;
    arvalid = 1'b1; araddr = 32'h0001_0000;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || arready !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL bp_hold got %0d bad cycles exp 0", bad);
    else pass_cnt++;
    bready = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({bvalid, arready} !== 2'b01) $display("FAIL bp_release got %b exp 01", {bvalid, arready});
    else pass_cnt++;
    @(negedge clk);
    arvalid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rvalid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (!ok || rdata !== 32'hDEAD_BEEF) $display("FAIL bp_read got %h (seen %0d) exp deadbeef", rdata, ok);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok;
    pready = 3'b000;
    start_write(32'h0000_0060, 32'hCAFE_F00D);
    ok = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (penable) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (!ok) $display("FAIL rst_reach_access got 0 exp 1");
    else pass_cnt++;
    resetn = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({psel, penable, bvalid, rvalid, awready, arready} !== 8'b0)
      $display("FAIL rst_mid_ctrl got %b exp 0", {psel, penable, bvalid, rvalid, awready, arready});
    else pass_cnt++;
    total_cnt++;
    if ({paddr, pwdata, bresp} !== '0) $display("FAIL rst_mid_data got %h %h %b exp 0", paddr, pwdata, bresp);
    else pass_cnt++;
    resetn = 1'b1;
    pready = 3'b111;
    repeat (4) @(negedge clk);
    #1;
    total_cnt++;
    if ({bvalid, psel} !== 4'b0) $display("FAIL rst_discard got %b exp 0000", {bvalid, psel});
    else pass_cnt++;
  endtask

  initial begin
    resetn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    bready = 1'b1; rready = 1'b1;
    pready = 3'b111; pslverr = 3'b000;
    prdata = {32'h0BAD_0BAD, 32'hDEAD_BEEF, 32'h1234_5678};
    test_reset;
    test_write;
    test_read_wait;
    test_decerr;
    test_timeout;
    test_arbitration;
    test_backpressure;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
